key_event_decoder: RTL and testbench



---
 rtl/key_event_pkg.sv | 11 +
 rtl/key_edge_detect.sv | 13 +
 rtl/key_event_decoder.sv | 109 ++++++++++
 tb/tb_key_event_decoder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: state encoding and default counter width shared by the key event decoder.
package key_event_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      LONG   = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4
   } state_t;
   localparam int CNT_W_DEF = 20;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: press/release edges of the debounced active-low key.
// The previous level tracks key_n even during reset, so a key held through reset yields no press edge.
module key_edge_detect (
   input  logic sys_clk,
   input  logic key_n,
   output logic press,
   output logic rel
);
   logic key_d_q;
   always_ff @(posedge sys_clk) key_d_q <= key_n;
   assign press = key_d_q & ~key_n;
   assign rel   = ~key_d_q & key_n;
endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies key gestures into single/double/long one-cycle pulses.
// Optional auto-repeat while a long press is held is enabled with KEY_REPEAT_EN.
module key_event_decoder import key_event_pkg::*; #(
   parameter int               CNT_W       = CNT_W_DEF,
   parameter logic [CNT_W-1:0] LONG_CNT    = CNT_W'(1_000_000),
   parameter logic [CNT_W-1:0] DBL_GAP_CNT = CNT_W'(500_000)
`ifdef KEY_REPEAT_EN
   ,
   parameter logic [CNT_W-1:0] REPEAT_CNT  = CNT_W'(250_000)
`endif
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_n,
   output logic single_pulse,
   output logic double_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic busy
);
   localparam logic [CNT_W-1:0] LONG_M1 = LONG_CNT - 1'b1;
   localparam logic [CNT_W-1:0] GAP_M1  = DBL_GAP_CNT - 1'b1;
   logic press, rel;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic single_q, single_d, double_q, double_d, long_q, long_d, busy_q;
   key_edge_detect u_edge (.sys_clk(sys_clk), .key_n(key_n), .press(press), .rel(rel));
   // Edges are tested before thresholds so a coincident press/release always wins.
   always_comb begin
      state_d  = state_q;
      cnt_d    = &cnt_q ? cnt_q : cnt_q + 1'b1;
      single_d = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (press) state_d = PRESS1;
         end
         PRESS1: begin
            if (rel) begin
               state_d = WAIT2;
               cnt_d   = '0;
            end else if (cnt_q == LONG_M1) begin
               state_d = LONG;
               long_d  = 1'b1;
            end
         end
         LONG: if (rel) state_d = IDLE;
         WAIT2: begin
            if (press) state_d = PRESS2;
            else if (cnt_q == GAP_M1) begin
               state_d  = IDLE;
               single_d = 1'b1;
            end
         end
         PRESS2: begin
            if (rel) begin
               state_d  = IDLE;
               double_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         single_q <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         single_q <= single_d;
         double_q <= double_d;
         long_q   <= long_d;
         busy_q   <= state_d != IDLE;
      end
   end
   assign single_pulse = single_q;
   assign double_pulse = double_q;
   assign long_pulse   = long_q;
   assign busy         = busy_q;
`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_M1 = REPEAT_CNT - 1'b1;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic rep_q, rep_d;
   // Repeat counter restarts on LONG entry; a release suppresses the pulse of that cycle.
   always_comb begin
      rcnt_d = (state_q == LONG && state_d == LONG) ? ((rcnt_q == REP_M1) ? '0 : rcnt_q + 1'b1) : '0;
      rep_d  = state_q == LONG && !rel && rcnt_q == REP_M1;
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rcnt_q <= '0;
         rep_q  <= 1'b0;
      end else begin
         rcnt_q <= rcnt_d;
         rep_q  <= rep_d;
      end
   end
   assign repeat_pulse = rep_q;
`else
   assign repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gesture checks with LONG_CNT=10, DBL_GAP_CNT=8, REPEAT_CNT=4.
module tb_key_event_decoder;
   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic key_n = 1'b1;
   logic single_pulse, double_pulse, long_pulse, repeat_pulse, busy;
   int checks = 0, errors = 0;
   int t = 0;
   int n_s, n_d, n_l, n_r, t_s, t_d, t_l, t_bf, ovl;
   int rep_t[$];
   logic busy_prev = 1'b0;
   int p, r, r2;
   always #5 sys_clk = ~sys_clk;
   key_event_decoder #(
      .CNT_W(20), .LONG_CNT(20'd10), .DBL_GAP_CNT(20'd8)
`ifdef KEY_REPEAT_EN
      , .REPEAT_CNT(20'd4)
`endif
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_n(key_n),
      .single_pulse(single_pulse), .double_pulse(double_pulse), .long_pulse(long_pulse),
      .repeat_pulse(repeat_pulse), .busy(busy)
   );
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic clr();
      n_s = 0; n_d = 0; n_l = 0; n_r = 0;
      t_s = -1; t_d = -1; t_l = -1; t_bf = -1; ovl = 0;
      rep_t.delete();
   endtask
   // t numbers the posedge just taken; outputs sampled 1 time unit after it.
   task automatic step(input logic k);
      key_n = k;
      @(posedge sys_clk);
      #1;
      t++;
      if (single_pulse === 1'b1) begin if (n_s == 0) t_s = t; n_s++; end
      if (double_pulse === 1'b1) begin if (n_d == 0) t_d = t; n_d++; end
      if (long_pulse === 1'b1) begin if (n_l == 0) t_l = t; n_l++; end
      if (repeat_pulse === 1'b1) begin n_r++; rep_t.push_back(t); end
      if (busy_prev && busy === 1'b0) t_bf = t;
      busy_prev = busy;
      if (int'(single_pulse) + int'(double_pulse) + int'(long_pulse) > 1) ovl++;
   endtask
   task automatic hold(input logic k, input int n);
      repeat (n) step(k);
   endtask
   initial begin
      clr();
      hold(1'b1, 2);
      chk("rst_single", int'(single_pulse), 0);
      chk("rst_double", int'(double_pulse), 0);
      chk("rst_long", int'(long_pulse), 0);
      chk("rst_repeat", int'(repeat_pulse), 0);
      chk("rst_busy", int'(busy), 0);
      sys_rst = 1'b0;
      hold(1'b1, 3);
      // single click
      clr();
      hold(1'b0, 3);
      chk("sgl_busy_high", int'(busy), 1);
      r = t + 1;
      hold(1'b1, 12);
      chk("sgl_count", n_s, 1);
      chk("sgl_time", t_s - r, 8);
      chk("sgl_no_double", n_d, 0);
      chk("sgl_no_long", n_l, 0);
      chk("sgl_busy_fall", t_bf - r, 8);
      // double click
      clr();
      hold(1'b0, 3);
      hold(1'b1, 4);
      hold(1'b0, 3);
      r2 = t + 1;
      hold(1'b1, 12);
      chk("dbl_count", n_d, 1);
      chk("dbl_time", t_d - r2, 0);
      chk("dbl_no_single", n_s, 0);
      chk("dbl_busy_fall", t_bf - r2, 0);
      // long press
      clr();
      p = t + 1;
      hold(1'b0, 20);
      hold(1'b1, 12);
      chk("long_count", n_l, 1);
      chk("long_time", t_l - p, 10);
      chk("long_no_single", n_s, 0);
      chk("long_no_double", n_d, 0);
      // gap of 8 released cycles: too late for a double
      clr();
      hold(1'b0, 3);
      r = t + 1;
      hold(1'b1, 9);
      hold(1'b0, 3);
      hold(1'b1, 12);
      chk("gap8_first_single", t_s - r, 8);
      chk("gap8_single_count", n_s, 2);
      chk("gap8_no_double", n_d, 0);
      // gap of 7 released cycles: double
      clr();
      hold(1'b0, 3);
      hold(1'b1, 8);
      hold(1'b0, 3);
      r2 = t + 1;
      hold(1'b1, 12);
      chk("gap7_double", n_d, 1);
      chk("gap7_double_time", t_d - r2, 0);
      chk("gap7_no_single", n_s, 0);
      // reset mid-PRESS1 with key held
      clr();
      hold(1'b0, 4);
      chk("rstg_busy_before", int'(busy), 1);
      sys_rst = 1'b1;
      step(1'b0);
      chk("rstg_busy_in_reset", int'(busy), 0);
      sys_rst = 1'b0;
      hold(1'b0, 15);
      chk("rstg_busy_after", int'(busy), 0);
      chk("rstg_pulses", n_s + n_d + n_l + n_r, 0);
      step(1'b1);
      step(1'b0);
      chk("rstg_new_press", int'(busy), 1);
      hold(1'b1, 12);
      chk("rstg_new_single", n_s, 1);
`ifdef KEY_REPEAT_EN
      clr();
      p = t + 1;
      hold(1'b0, 26);
      hold(1'b1, 8);
      chk("rep_long_time", t_l - p, 10);
      chk("rep_count", n_r, 3);
      chk("rep_t0", (rep_t.size() > 0) ? rep_t[0] - p : -1, 14);
      chk("rep_t1", (rep_t.size() > 1) ? rep_t[1] - p : -1, 18);
      chk("rep_t2", (rep_t.size() > 2) ? rep_t[2] - p : -1, 22);
`else
      chk("norep_count", n_r, 0);
`endif
      chk("no_overlap", ovl, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
